// File: rtl/clock_monitor.sv
// Measures period, high time, duty cycle and period envelope of an asynchronous clock sampled on clk.
// Period/min/max/in_tol valid one cycle after a detected rise, duty_pct/meas_valid eight cycles after; no backpressure.
module clock_monitor #(
    parameter int CNT_W      = 16,
    parameter int EXP_PERIOD = 20,
    parameter int TOL_PCT    = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mon_clk,
    input  logic             clr,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic [6:0]       duty_pct,
    output logic [CNT_W-1:0] period_min,
    output logic [CNT_W-1:0] period_max,
    output logic             meas_valid,
    output logic             in_tol,
    output logic             timeout
);

    localparam int DW = CNT_W + 7;
    localparam int TW = CNT_W + 32;
    localparam logic [CNT_W-1:0] ONES    = '1;
    localparam logic [TW-1:0]    EXP_W   = TW'(EXP_PERIOD);
    localparam logic [TW-1:0]    TOL_LIM = TW'(EXP_PERIOD) * TW'(TOL_PCT);

    typedef enum logic [1:0] {IDLE, MEAS, DIV} state_t;

    state_t state, state_nxt;

    logic             s1, s2, s_d;
    logic             rise, fall, sat;
    logic [CNT_W-1:0] cnt, hi_lat;
    logic [DW-1:0]    rem, dvs;
    logic [6:0]       quo, quo_nxt;
    logic [2:0]       iter;
    logic             rem_ge, div_last;
    logic             capture, first_rise, set_tmo, div_step, div_done;
    logic [TW-1:0]    cnt_w, diff;
    logic             tol_ok;
    logic [CNT_W-1:0] min_base, max_base;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1  <= 1'b0;
            s2  <= 1'b0;
            s_d <= 1'b0;
        end else begin
            s1  <= mon_clk;
            s2  <= s1;
            s_d <= s2;
        end
    end

    assign rise = s2 & ~s_d;
    assign fall = ~s2 & s_d;
    assign sat  = (cnt == ONES);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            hi_lat <= '0;
        end else begin
            if (rise)
                cnt <= CNT_W'(1);
            else if (!sat)
                cnt <= cnt + CNT_W'(1);
            if (fall)
                hi_lat <= cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    assign div_last = (iter == 3'd6);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (rise) state_nxt = MEAS;
            MEAS: begin
                if (rise)
                    state_nxt = DIV;
                else if (sat)
                    state_nxt = IDLE;
            end
            DIV: begin
                if (rise)
                    state_nxt = DIV;
                else if (sat)
                    state_nxt = IDLE;
                else if (div_last)
                    state_nxt = MEAS;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A rise in DIV recaptures and restarts, so an aborted division never reaches div_done.
    always_comb begin
        capture    = 1'b0;
        first_rise = 1'b0;
        set_tmo    = 1'b0;
        div_step   = 1'b0;
        div_done   = 1'b0;
        case (state)
            IDLE: first_rise = rise;
            MEAS: begin
                capture = rise;
                set_tmo = !rise && sat;
            end
            DIV: begin
                capture  = rise;
                set_tmo  = !rise && sat;
                div_step = !rise && !sat;
                div_done = !rise && !sat && div_last;
            end
            default: ;
        endcase
    end

    assign cnt_w  = TW'(cnt);
    assign diff   = (cnt_w >= EXP_W) ? (cnt_w - EXP_W) : (EXP_W - cnt_w);
    assign tol_ok = ((diff * TW'(100)) <= TOL_LIM);

    assign min_base = clr ? ONES : period_min;
    assign max_base = clr ? '0   : period_max;

    assign rem_ge  = (rem >= dvs);
    assign quo_nxt = {quo[5:0], rem_ge};

    always_ff @(posedge clk) begin
        if (rst) begin
            period     <= '0;
            high_time  <= '0;
            duty_pct   <= '0;
            period_min <= ONES;
            period_max <= '0;
            meas_valid <= 1'b0;
            in_tol     <= 1'b0;
            timeout    <= 1'b0;
            rem        <= '0;
            dvs        <= '0;
            quo        <= '0;
            iter       <= '0;
        end else begin
            meas_valid <= div_done;
            if (clr) begin
                period_min <= ONES;
                period_max <= '0;
            end
            if (capture) begin
                period     <= cnt;
                high_time  <= hi_lat;
                period_min <= (cnt < min_base) ? cnt : min_base;
                period_max <= (cnt > max_base) ? cnt : max_base;
                in_tol     <= tol_ok;
                // Divisor pre-shifted by 6 so seven compare/subtract steps yield the quotient MSB first.
                rem        <= DW'(hi_lat) * DW'(100);
                dvs        <= DW'(cnt) << 6;
                quo        <= '0;
                iter       <= '0;
            end
            if (div_step) begin
                rem  <= rem_ge ? (rem - dvs) : rem;
                dvs  <= dvs >> 1;
                quo  <= quo_nxt;
                iter <= iter + 3'd1;
            end
            if (div_done)
                duty_pct <= quo_nxt;
            if (set_tmo)
                timeout <= 1'b1;
            else if (first_rise)
                timeout <= 1'b0;
        end
    end

endmodule

// File: tb/tb_clock_monitor.sv
// Directed bench for clock_monitor: a default-parameter instance plus a CNT_W=8 instance for the stuck-clock timeout.
module tb_clock_monitor;

    logic clk, rst, clr, mon_a, mon_b;

    logic [15:0] per_a, hi_a, min_a, max_a;
    logic [6:0]  duty_a;
    logic        mvs_a, tol_a, to_a;

    logic [7:0]  per_b, hi_b, min_b, max_b;
    logic [6:0]  duty_b;
    logic        mvs_b, tol_b, to_b;

    int checks = 0;
    int errors = 0;
    int k = 0;
    int mv_a = 0;
    int mv_b = 0;
    int last_mv_k = 0;
    int to_k = 0;
    logic sel_b = 1'b0;

    clock_monitor #(.CNT_W(16), .EXP_PERIOD(20), .TOL_PCT(10)) dut_a (
        .clk(clk), .rst(rst), .mon_clk(mon_a), .clr(clr),
        .period(per_a), .high_time(hi_a), .duty_pct(duty_a),
        .period_min(min_a), .period_max(max_a),
        .meas_valid(mvs_a), .in_tol(tol_a), .timeout(to_a)
    );

    clock_monitor #(.CNT_W(8), .EXP_PERIOD(20), .TOL_PCT(10)) dut_b (
        .clk(clk), .rst(rst), .mon_clk(mon_b), .clr(clr),
        .period(per_b), .high_time(hi_b), .duty_pct(duty_b),
        .period_min(min_b), .period_max(max_b),
        .meas_valid(mvs_b), .in_tol(tol_b), .timeout(to_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clk cycle; outputs are sampled on the falling edge.
    task automatic step();
        @(negedge clk);
        k++;
        if (mvs_a === 1'b1) begin
            mv_a++;
            last_mv_k = k;
        end
        if (mvs_b === 1'b1) mv_b++;
        if (to_b === 1'b1 && to_k == 0) to_k = k;
    endtask

    task automatic set_mon(input logic v);
        if (sel_b) mon_b = v;
        else mon_a = v;
    endtask

    // One mon_clk period of p clk cycles, high for h; clr/rst pulse after step index clr_at/rst_at.
    task automatic drive_cycle(input int p, input int h, input int clr_at, input int rst_at);
        for (int i = 0; i < p; i++) begin
            if (i == 0) begin
                set_mon(1'b1);
                k = 0;
            end
            if (i == h) set_mon(1'b0);
            step();
            clr = (i == clr_at);
            rst = (i == rst_at);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; clr = 1'b0; mon_a = 1'b0; mon_b = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (per_a !== 16'd0) begin errors++; $display("FAIL reset_period: got %0d want 0", per_a); end
        checks++; if (hi_a !== 16'd0) begin errors++; $display("FAIL reset_high: got %0d want 0", hi_a); end
        checks++; if (duty_a !== 7'd0) begin errors++; $display("FAIL reset_duty: got %0d want 0", duty_a); end
        checks++; if (min_a !== 16'hFFFF) begin errors++; $display("FAIL reset_min: got %0h want ffff", min_a); end
        checks++; if (max_a !== 16'd0) begin errors++; $display("FAIL reset_max: got %0d want 0", max_a); end
        checks++; if (mvs_a !== 1'b0) begin errors++; $display("FAIL reset_mv: got %0b want 0", mvs_a); end
        checks++; if (tol_a !== 1'b0) begin errors++; $display("FAIL reset_tol: got %0b want 0", tol_a); end
        checks++; if (to_a !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %0b want 0", to_a); end
        checks++; if (min_b !== 8'hFF) begin errors++; $display("FAIL reset_min8: got %0h want ff", min_b); end
        rst = 1'b0;
    endtask

    task automatic test_steady();
        mv_a = 0;
        repeat (4) drive_cycle(20, 10, -1, -1);
        checks++; if (per_a !== 16'd20) begin errors++; $display("FAIL steady_period: got %0d want 20", per_a); end
        checks++; if (hi_a !== 16'd10) begin errors++; $display("FAIL steady_high: got %0d want 10", hi_a); end
        checks++; if (duty_a !== 7'd50) begin errors++; $display("FAIL steady_duty: got %0d want 50", duty_a); end
        checks++; if (tol_a !== 1'b1) begin errors++; $display("FAIL steady_tol: got %0b want 1", tol_a); end
        checks++; if (mv_a != 3) begin errors++; $display("FAIL steady_mv_count: got %0d want 3", mv_a); end
        checks++; if (last_mv_k != 10) begin errors++; $display("FAIL steady_mv_latency: got %0d want 10", last_mv_k); end
        checks++; if (to_a !== 1'b0) begin errors++; $display("FAIL steady_timeout: got %0b want 0", to_a); end
    endtask

    task automatic test_duty();
        repeat (2) drive_cycle(40, 12, -1, -1);
        checks++; if (per_a !== 16'd40) begin errors++; $display("FAIL duty40_period: got %0d want 40", per_a); end
        checks++; if (hi_a !== 16'd12) begin errors++; $display("FAIL duty40_high: got %0d want 12", hi_a); end
        checks++; if (duty_a !== 7'd30) begin errors++; $display("FAIL duty40_duty: got %0d want 30", duty_a); end
        checks++; if (tol_a !== 1'b0) begin errors++; $display("FAIL duty40_tol: got %0b want 0", tol_a); end
        repeat (2) drive_cycle(33, 10, -1, -1);
        checks++; if (per_a !== 16'd33) begin errors++; $display("FAIL duty33_period: got %0d want 33", per_a); end
        checks++; if (duty_a !== 7'd30) begin errors++; $display("FAIL duty33_duty: got %0d want 30", duty_a); end
        checks++; if (tol_a !== 1'b0) begin errors++; $display("FAIL duty33_tol: got %0b want 0", tol_a); end
    endtask

    task automatic test_jitter();
        drive_cycle(19, 8, 5, -1);
        checks++; if (min_a !== 16'hFFFF) begin errors++; $display("FAIL clr_min: got %0h want ffff", min_a); end
        checks++; if (max_a !== 16'd0) begin errors++; $display("FAIL clr_max: got %0d want 0", max_a); end
        drive_cycle(21, 8, -1, -1);
        drive_cycle(23, 8, -1, -1);
        drive_cycle(18, 8, -1, -1);
        checks++; if (per_a !== 16'd23) begin errors++; $display("FAIL jit_period23: got %0d want 23", per_a); end
        checks++; if (tol_a !== 1'b0) begin errors++; $display("FAIL jit_tol23: got %0b want 0", tol_a); end
        drive_cycle(21, 8, -1, -1);
        checks++; if (per_a !== 16'd18) begin errors++; $display("FAIL jit_period18: got %0d want 18", per_a); end
        checks++; if (tol_a !== 1'b1) begin errors++; $display("FAIL jit_tol18: got %0b want 1", tol_a); end
        checks++; if (min_a !== 16'd18) begin errors++; $display("FAIL jit_min: got %0d want 18", min_a); end
        checks++; if (max_a !== 16'd23) begin errors++; $display("FAIL jit_max: got %0d want 23", max_a); end
        drive_cycle(21, 8, 1, -1);
        checks++; if (min_a !== 16'd21) begin errors++; $display("FAIL clrcap_min: got %0d want 21", min_a); end
        checks++; if (max_a !== 16'd21) begin errors++; $display("FAIL clrcap_max: got %0d want 21", max_a); end
    endtask

    task automatic test_short();
        mv_a = 0;
        repeat (4) drive_cycle(6, 3, -1, -1);
        checks++; if (per_a !== 16'd6) begin errors++; $display("FAIL short_period: got %0d want 6", per_a); end
        checks++; if (hi_a !== 16'd3) begin errors++; $display("FAIL short_high: got %0d want 3", hi_a); end
        checks++; if (mv_a != 0) begin errors++; $display("FAIL short_no_mv: got %0d want 0", mv_a); end
        mv_a = 0;
        repeat (3) drive_cycle(20, 10, -1, -1);
        checks++; if (per_a !== 16'd20) begin errors++; $display("FAIL resume_period: got %0d want 20", per_a); end
        checks++; if (duty_a !== 7'd50) begin errors++; $display("FAIL resume_duty: got %0d want 50", duty_a); end
        checks++; if (mv_a != 3) begin errors++; $display("FAIL resume_mv: got %0d want 3", mv_a); end
    endtask

    task automatic test_timeout();
        sel_b = 1'b1;
        repeat (2) drive_cycle(20, 10, -1, -1);
        checks++; if (per_b !== 8'd20) begin errors++; $display("FAIL to_pre_period: got %0d want 20", per_b); end
        checks++; if (to_b !== 1'b0) begin errors++; $display("FAIL to_pre_timeout: got %0b want 0", to_b); end
        to_k = 0;
        for (int i = 0; i < 400 && to_k == 0; i++) step();
        checks++; if (to_k != 258) begin errors++; $display("FAIL to_assert_cycle: got %0d want 258", to_k); end
        checks++; if (per_b !== 8'd20) begin errors++; $display("FAIL to_hold_period: got %0d want 20", per_b); end
        mv_b = 0;
        drive_cycle(30, 10, -1, -1);
        checks++; if (to_b !== 1'b0) begin errors++; $display("FAIL to_cleared: got %0b want 0", to_b); end
        checks++; if (mv_b != 0) begin errors++; $display("FAIL to_first_rise_mv: got %0d want 0", mv_b); end
        checks++; if (per_b !== 8'd20) begin errors++; $display("FAIL to_first_rise_period: got %0d want 20", per_b); end
        drive_cycle(20, 10, -1, -1);
        checks++; if (per_b !== 8'd30) begin errors++; $display("FAIL to_second_period: got %0d want 30", per_b); end
        checks++; if (hi_b !== 8'd10) begin errors++; $display("FAIL to_second_high: got %0d want 10", hi_b); end
        checks++; if (duty_b !== 7'd33) begin errors++; $display("FAIL to_second_duty: got %0d want 33", duty_b); end
        checks++; if (mv_b != 1) begin errors++; $display("FAIL to_second_mv: got %0d want 1", mv_b); end
        checks++; if (tol_b !== 1'b0) begin errors++; $display("FAIL to_second_tol: got %0b want 0", tol_b); end
        sel_b = 1'b0;
    endtask

    task automatic test_reset_mid();
        mv_a = 0;
        drive_cycle(20, 4, -1, 6);
        checks++; if (per_a !== 16'd0) begin errors++; $display("FAIL rmid_period: got %0d want 0", per_a); end
        checks++; if (hi_a !== 16'd0) begin errors++; $display("FAIL rmid_high: got %0d want 0", hi_a); end
        checks++; if (duty_a !== 7'd0) begin errors++; $display("FAIL rmid_duty: got %0d want 0", duty_a); end
        checks++; if (min_a !== 16'hFFFF) begin errors++; $display("FAIL rmid_min: got %0h want ffff", min_a); end
        checks++; if (max_a !== 16'd0) begin errors++; $display("FAIL rmid_max: got %0d want 0", max_a); end
        checks++; if (tol_a !== 1'b0) begin errors++; $display("FAIL rmid_tol: got %0b want 0", tol_a); end
        checks++; if (mv_a != 0) begin errors++; $display("FAIL rmid_stray_mv: got %0d want 0", mv_a); end
        drive_cycle(20, 10, -1, -1);
        checks++; if (per_a !== 16'd0) begin errors++; $display("FAIL rmid_first_rise: got %0d want 0", per_a); end
        checks++; if (mv_a != 0) begin errors++; $display("FAIL rmid_first_mv: got %0d want 0", mv_a); end
        drive_cycle(20, 10, -1, -1);
        checks++; if (per_a !== 16'd20) begin errors++; $display("FAIL rmid_second_period: got %0d want 20", per_a); end
        checks++; if (duty_a !== 7'd50) begin errors++; $display("FAIL rmid_second_duty: got %0d want 50", duty_a); end
        checks++; if (mv_a != 1) begin errors++; $display("FAIL rmid_second_mv: got %0d want 1", mv_a); end
        checks++; if (min_a !== 16'd20 || max_a !== 16'd20) begin errors++; $display("FAIL rmid_minmax: got %0d/%0d want 20/20", min_a, max_a); end
    endtask

    initial begin
        test_reset();
        test_steady();
        test_duty();
        test_jitter();
        test_short();
        test_timeout();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
